// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, default
// latencies and FSM state type.
package mdu_sched_pkg;

  typedef enum logic [2:0] {
    MdOpMult  = 3'd0,
    MdOpMultu = 3'd1,
    MdOpDiv   = 3'd2,
    MdOpDivu  = 3'd3,
    MdOpMthi  = 3'd4,
    MdOpMtlo  = 3'd5,
    MdOpNone6 = 3'd6,
    MdOpNone7 = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

  localparam int unsigned MultLatDefault = 5;
  localparam int unsigned DivLatDefault  = 10;
  localparam int unsigned CntW           = 16;

  // Ops 0-3 occupy the arithmetic unit; 4-5 are moves, 6-7 are no-ops.
  function automatic logic is_arith_op(logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// Handshake bundle between the pipeline (master) and the MD scheduler (slave).
interface mdu_sched_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, d_md_use,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, op, a, b, d_md_use,
    output busy, md_stall, hi, lo
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply and 32-bit divide on the latched operands.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  md_op_e      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_o
);

  logic               is_signed;
  logic               is_div;
  logic [63:0]        a_ext;
  logic [63:0]        b_ext;
  logic [63:0]        prod;
  logic signed [32:0] dvd;
  logic signed [32:0] dvs;
  logic signed [32:0] quo;
  logic signed [32:0] rem;
  logic               unused_div_msb;

  assign is_signed  = (op_i == MdOpMult) || (op_i == MdOpDiv);
  assign is_div     = (op_i == MdOpDiv) || (op_i == MdOpDivu);
  assign div_zero_o = is_div && (b_i == 32'd0);

  // Sign- or zero-extension lets one 64-bit product serve both mult flavours.
  always_comb begin
    a_ext = is_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    b_ext = is_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod  = a_ext * b_ext;
  end

  // 33-bit signed divide covers divu and keeps -2^31 / -1 well defined.
  always_comb begin
    dvd = {is_signed & a_i[31], a_i};
    dvs = div_zero_o ? 33'sd1 : {is_signed & b_i[31], b_i};
    quo = dvd / dvs;
    rem = dvd % dvs;
  end

  assign unused_div_msb = quo[32] ^ rem[32];

  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      MdOpMult, MdOpMultu: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
      MdOpDiv, MdOpDivu: begin
        hi_o = rem[31:0];
        lo_o = quo[31:0];
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MD unit scheduler: IDLE/BUSY FSM, latency counter, HI/LO and
// the stall request for a D-stage MD instruction.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int unsigned MULT_LAT = MultLatDefault,
  parameter int unsigned DIV_LAT  = DivLatDefault
) (
  input  logic         clk,
  input  logic         reset,
  mdu_sched_if.slave   md
);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  md_op_e          op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            busy_q, busy_d;

  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            div_zero;
  md_op_e          start_op;

  assign start_op = md_op_e'(md.op);

  mdu_arith u_arith (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .hi_o       (res_hi),
    .lo_o       (res_lo),
    .div_zero_o (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md.start) begin
          case (start_op)
            MdOpMult, MdOpMultu, MdOpDiv, MdOpDivu: begin
              op_d    = start_op;
              a_d     = md.a;
              b_d     = md.b;
              cnt_d   = (start_op == MdOpMult || start_op == MdOpMultu) ?
                        CntW'(MULT_LAT) : CntW'(DIV_LAT);
              state_d = StBusy;
            end
            MdOpMthi: hi_d = md.a;
            MdOpMtlo: lo_d = md.a;
            default:  ;
          endcase
        end
      end
      StBusy: begin
        // Start requests here are dropped; only the countdown advances.
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (!div_zero) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StBusy);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MdOpMult;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_stall = md.d_md_use & (busy_q | (md.start & is_arith_op(md.op)));

endmodule
